// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide, one bit per cycle)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_funct3_t;

    state_t           state, state_nx;
    logic [2:0]       op;
    logic             neg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, dsr;
    logic             accept, sa, sb, neg_in, div_zero, ovf, special;
    logic [WIDTH-1:0] abs_a, abs_b, special_res;
    logic [WIDTH:0]   msum, dshift, ddiff;
    logic [WIDTH-1:0] hi_nx, lo_nx, div_val, div_res, mul_res, fix_res;
    logic [2*WIDTH-1:0] prod_s;

    assign ready  = state == IDLE;
    assign busy   = state == CALC || state == FIX;
    assign done   = state == DONE && !flush;
    assign accept = start && ready && !flush;

    // Operand conditioning at accept: magnitudes, result sign and RISC-V fast-path cases
    always_comb begin
        sa          = a[WIDTH-1] && !(funct3 inside {MULHU, DIVU, REMU});
        sb          = b[WIDTH-1] && (funct3 inside {MUL, MULH, DIV, REM});
        abs_a       = sa ? -a : a;
        abs_b       = sb ? -b : b;
        neg_in      = (funct3 inside {REM, REMU}) ? sa : sa ^ sb;
        div_zero    = funct3[2] && b == '0;
        ovf         = (funct3 inside {DIV, REM}) && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
        special     = div_zero || ovf;
        special_res = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
    end

    // hi/lo hold {product} for multiply and {remainder, quotient} for divide
    always_comb begin
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
        dshift  = {hi, lo[WIDTH-1]};
        ddiff   = dshift - {1'b0, dsr};
        hi_nx   = op[2] ? (ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0]) : msum[WIDTH:1];
        lo_nx   = op[2] ? {lo[WIDTH-2:0], ~ddiff[WIDTH]} : {msum[0], lo[WIDTH-1:1]};
        prod_s  = neg ? -{hi, lo} : {hi, lo};
        mul_res = op == MUL ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        div_val = op[1] ? hi : lo;
        div_res = neg ? -div_val : div_val;
        fix_res = op[2] ? div_res : mul_res;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    state_nx = cnt == CW'(1) ? FIX : CALC;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (flush && state != IDLE)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            dsr    <= '0;
            result <= '0;
        end else if (accept) begin
            op  <= funct3;
            neg <= neg_in;
            hi  <= '0;
            lo  <= funct3[2] ? abs_a : abs_b;
            dsr <= funct3[2] ? abs_b : abs_a;
            cnt <= special ? '0 : CW'(WIDTH);
            if (special)
                result <= special_res;
        end else if (state == CALC && !flush) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt - CW'(1);
        end else if (state == FIX && !flush) begin
            result <= fix_res;
        end
    end
endmodule
